// File: rtl/ysyx_25020037_bypass_buf.sv
// Operand-forwarding buffer: program-ordered queue of in-flight GPR producers feeding EXU operands.
// Optional macro YSYX_25020037_LDRET_FWD_EN forwards returning load data in its return cycle.
module ysyx_25020037_bypass_buf #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_valid,
    input  logic                        alloc_we,
    input  logic [REG_AW-1:0]           alloc_rd,
    input  logic                        alloc_is_load,
    input  logic [XLEN-1:0]             alloc_data,
    output logic                        alloc_ready,
    input  logic                        ld_ret_valid,
    input  logic [XLEN-1:0]             ld_ret_data,
    input  logic                        wb_valid,
    input  logic                        flush,
    input  logic [NUM_SRC*REG_AW-1:0]   src_idx,
    input  logic [NUM_SRC*XLEN-1:0]     src_rf_data,
    output logic [NUM_SRC*XLEN-1:0]     src_data,
    output logic [NUM_SRC-1:0]          src_hit,
    output logic                        stall,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_pend;
    logic [REG_AW-1:0] r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [PW-1:0]     w_ord [DEPTH];
    logic              w_full;
    logic              w_wb_do;
    logic              w_alloc_do;
    logic              w_ld_hit;
    logic [PW-1:0]     w_ld_idx;
    logic              w_ld_to_new;
    logic [NUM_SRC-1:0] w_wait;

    // w_ord[i] is the slot holding the i-th oldest entry
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_ord
            assign w_ord[g] = r_head + PW'(g);
        end
    endgenerate

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_wb_do     = wb_valid & r_valid[r_head] & ~r_pend[r_head];
    assign alloc_ready = ~w_full | w_wb_do;
    assign w_alloc_do  = alloc_valid & alloc_we & (alloc_rd != '0) & alloc_ready;
    assign w_ld_to_new = ld_ret_valid & ~w_ld_hit & w_alloc_do & alloc_is_load;
    assign count       = r_count;

    // Oldest pending entry: scan youngest to oldest so the oldest match is written last
    always_comb begin
        w_ld_hit = 1'b0;
        w_ld_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_valid[w_ord[i]] && r_pend[w_ord[i]]) begin
                w_ld_hit = 1'b1;
                w_ld_idx = w_ord[i];
            end
        end
    end

    // Per-port lookup: scan oldest to youngest so the youngest match wins
    always_comb begin
        src_data = src_rf_data;
        src_hit  = '0;
        w_wait   = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            if (src_idx[p*REG_AW +: REG_AW] != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[w_ord[i]] && r_rd[w_ord[i]] == src_idx[p*REG_AW +: REG_AW]) begin
                        src_data[p*XLEN +: XLEN] = r_data[w_ord[i]];
                        src_hit[p]               = 1'b1;
                        w_wait[p]                = r_pend[w_ord[i]];
`ifdef YSYX_25020037_LDRET_FWD_EN
                        if (r_pend[w_ord[i]] && ld_ret_valid && w_ld_hit && w_ld_idx == w_ord[i]) begin
                            src_data[p*XLEN +: XLEN] = ld_ret_data;
                            w_wait[p]                = 1'b0;
                        end
`endif
                    end
                end
            end
        end
    end

    assign stall = |w_wait;

    // Control state: valid/pend flags, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_pend  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_pend  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (ld_ret_valid && w_ld_hit) begin
                r_pend[w_ld_idx] <= 1'b0;
            end
            if (w_wb_do) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            // Placed after the free so a full-queue alloc reusing the head slot wins
            if (w_alloc_do) begin
                r_valid[r_tail] <= 1'b1;
                r_pend[r_tail]  <= alloc_is_load & ~w_ld_to_new;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_alloc_do) - CW'(w_wb_do);
        end
    end

    // Payload storage carries no reset; valid flags qualify it
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (ld_ret_valid && w_ld_hit) begin
                r_data[w_ld_idx] <= ld_ret_data;
            end
            if (w_alloc_do) begin
                r_rd[r_tail]   <= alloc_rd;
                r_data[r_tail] <= w_ld_to_new ? ld_ret_data :
                                  (alloc_is_load ? '0 : alloc_data);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_bypass_buf.sv
// Directed bench for ysyx_25020037_bypass_buf (DEPTH=4, two source ports).
module tb_ysyx_25020037_bypass_buf;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam logic [31:0] RF0 = 32'h0000_5555;
    localparam logic [31:0] RF1 = 32'h0000_AAAA;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid = 1'b0, alloc_we = 1'b0, alloc_is_load = 1'b0;
    logic [AW-1:0]   alloc_rd = '0;
    logic [XLEN-1:0] alloc_data = '0;
    logic            alloc_ready;
    logic            ld_ret_valid = 1'b0;
    logic [XLEN-1:0] ld_ret_data = '0;
    logic            wb_valid = 1'b0, flush = 1'b0;
    logic [2*AW-1:0] src_idx = '0;
    logic [63:0]     src_rf_data;
    logic [63:0]     src_data;
    logic [1:0]      src_hit;
    logic            stall;
    logic [2:0]      count;

    int n_cmp = 0;
    int n_err = 0;

    assign src_rf_data = {RF1, RF0};

    ysyx_25020037_bypass_buf #(.XLEN(32), .DEPTH(4), .NUM_SRC(2), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_we(alloc_we), .alloc_rd(alloc_rd),
        .alloc_is_load(alloc_is_load), .alloc_data(alloc_data), .alloc_ready(alloc_ready),
        .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
        .wb_valid(wb_valid), .flush(flush),
        .src_idx(src_idx), .src_rf_data(src_rf_data),
        .src_data(src_data), .src_hit(src_hit), .stall(stall), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_we = 1'b0; alloc_is_load = 1'b0;
        alloc_rd = '0; alloc_data = '0;
        ld_ret_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] d, input logic ld);
        alloc_valid = 1'b1; alloc_we = 1'b1; alloc_rd = rd; alloc_data = d; alloc_is_load = ld;
    endtask

    task automatic look(input logic [4:0] i0, input logic [4:0] i1);
        src_idx = {i1, i0};
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_stall", 32'(stall), 0);
        look(5'd5, 5'd0);
        chk("rst_hit", 32'(src_hit), 0);
        chk("rst_data0", src_data[31:0], RF0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // T1: forward after one cycle, invisible in the alloc cycle
        alloc(5'd5, 32'h11, 1'b0);
        look(5'd5, 5'd0);
        chk("t1_same_cycle_hit", 32'(src_hit), 0);
        tick(); idle();
        look(5'd5, 5'd0);
        chk("t1_data0", src_data[31:0], 32'h11);
        chk("t1_hit", 32'(src_hit), 32'b01);
        chk("t1_data1", src_data[63:32], RF1);
        chk("t1_stall", 32'(stall), 0);
        chk("t1_count", 32'(count), 1);
        wb_valid = 1'b1; tick(); idle();
        chk("t1_wb_count", 32'(count), 0);

        // T2: youngest wins
        alloc(5'd3, 32'hA, 1'b0); tick();
        alloc(5'd3, 32'hB, 1'b0); tick(); idle();
        look(5'd3, 5'd3);
        chk("t2_data0", src_data[31:0], 32'hB);
        chk("t2_data1", src_data[63:32], 32'hB);
        chk("t2_count", 32'(count), 2);
        wb_valid = 1'b1; tick(); idle(); look(5'd3, 5'd0);
        chk("t2_after_wb", src_data[31:0], 32'hB);
        chk("t2_after_wb_count", 32'(count), 1);
        wb_valid = 1'b1; tick(); idle(); look(5'd3, 5'd0);
        chk("t2_empty_hit", 32'(src_hit), 0);
        chk("t2_empty_data", src_data[31:0], RF0);

        // T3: pending load
        alloc(5'd7, 32'h999, 1'b1); tick(); idle();
        look(5'd0, 5'd7);
        chk("t3_stall", 32'(stall), 1);
        chk("t3_hit", 32'(src_hit), 32'b10);
        chk("t3_load_data", src_data[63:32], 0);
        wb_valid = 1'b1; tick(); idle();
        chk("t3_wb_pending_ignored", 32'(count), 1);
        ld_ret_valid = 1'b1; ld_ret_data = 32'hDEAD; #1;
`ifdef YSYX_25020037_LDRET_FWD_EN
        chk("t3_ret_cycle_stall", 32'(stall), 0);
        chk("t3_ret_cycle_data", src_data[63:32], 32'hDEAD);
`else
        chk("t3_ret_cycle_stall", 32'(stall), 1);
        chk("t3_ret_cycle_data", src_data[63:32], 0);
`endif
        tick(); idle(); #1;
        chk("t3_after_stall", 32'(stall), 0);
        chk("t3_after_data", src_data[63:32], 32'hDEAD);
        wb_valid = 1'b1; tick(); idle();
        chk("t3_count", 32'(count), 0);

        // T4: fill, then wb+alloc while full
        for (int i = 1; i <= 4; i++) begin
            alloc(5'(i), 32'h100 + 32'(i), 1'b0); tick();
        end
        idle(); #1;
        chk("t4_count_full", 32'(count), 4);
        chk("t4_ready_full", 32'(alloc_ready), 0);
        alloc(5'd9, 32'h109, 1'b0); #1;
        chk("t4_full_drop_ready", 32'(alloc_ready), 0);
        tick(); idle(); #1;
        chk("t4_full_no_alloc", 32'(count), 4);
        wb_valid = 1'b1; alloc(5'd9, 32'h109, 1'b0); #1;
        chk("t4_ready_wb", 32'(alloc_ready), 1);
        tick(); idle(); look(5'd9, 5'd1);
        chk("t4_count_after", 32'(count), 4);
        chk("t4_new_data", src_data[31:0], 32'h109);
        chk("t4_freed_hit", 32'(src_hit), 32'b01);
        chk("t4_freed_data", src_data[63:32], RF1);
        look(5'd4, 5'd2);
        chk("t4_wrap_data0", src_data[31:0], 32'h104);
        chk("t4_wrap_data1", src_data[63:32], 32'h102);
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; tick();
        end
        idle(); look(5'd9, 5'd0);
        chk("t4_drained", 32'(count), 0);
        chk("t4_drained_hit", 32'(src_hit), 0);

        // T5: flush beats same-cycle alloc and ld_ret; rd 0 never allocates
        alloc(5'd6, 32'h0, 1'b1); tick(); idle();
        flush = 1'b1; alloc(5'd8, 32'h88, 1'b0);
        ld_ret_valid = 1'b1; ld_ret_data = 32'h66;
        tick(); idle(); look(5'd6, 5'd8);
        chk("t5_count", 32'(count), 0);
        chk("t5_hit", 32'(src_hit), 0);
        chk("t5_stall", 32'(stall), 0);
        alloc(5'd0, 32'h55, 1'b0); tick(); idle(); look(5'd0, 5'd0);
        chk("t5_rd0_count", 32'(count), 0);
        chk("t5_idx0_data", src_data[31:0], RF0);

        // T6: asynchronous reset mid-stream
        alloc(5'd10, 32'h1, 1'b0); tick();
        alloc(5'd11, 32'h2, 1'b0); tick();
        alloc(5'd12, 32'h0, 1'b1); tick(); idle();
        look(5'd12, 5'd10);
        chk("t6_pre_stall", 32'(stall), 1);
        chk("t6_pre_count", 32'(count), 3);
        #1 rst = 1'b0; #1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_stall", 32'(stall), 0);
        chk("t6_rst_hit", 32'(src_hit), 0);
        @(negedge clk); rst = 1'b1;
        tick();
        ld_ret_valid = 1'b1; ld_ret_data = 32'h77; tick(); idle(); look(5'd12, 5'd10);
        chk("t6_ret_ignored_count", 32'(count), 0);
        chk("t6_ret_ignored_hit", 32'(src_hit), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
